// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard unit: forward-select encoding and the
// opcode set that the external decoder uses to drive id_use_* / id_long.
package hazard_scoreboard_pkg;

  localparam int FWD_W = 3;

  // Forward-select encoding; values 4-7 are never produced.
  typedef enum logic [FWD_W-1:0] {
    FWD_NONE = 3'd0,
    FWD_EXEC = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3
  } fwd_sel_e;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_LOAD   = 4'd4,
    OP_STORE  = 4'd5,
    OP_INPUT  = 4'd6,
    OP_OUTPUT = 4'd7,
    OP_BRANCH = 4'd8
  } opcode_e;

  // Long-latency producers are the ones tracked by the countdown scoreboard.
  function automatic logic op_is_long(input opcode_e op);
    return (op == OP_LOAD) || (op == OP_INPUT);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_sel.sv
// Per-operand forward selector: compares one source address against the
// EXEC/MEM/WB destinations and picks the youngest match (EXEC > MEM > WB).
module hazard_fwd_sel
  import hazard_scoreboard_pkg::*;
#(
  parameter int RA_W = 3
) (
  input  logic [RA_W-1:0] i_src,
  input  logic            i_use,
  input  logic            i_kill,
  input  logic [RA_W-1:0] i_ex_rd,
  input  logic            i_ex_we,
  input  logic [RA_W-1:0] i_mem_rd,
  input  logic            i_mem_we,
  input  logic [RA_W-1:0] i_wb_rd,
  input  logic            i_wb_we,
  output fwd_sel_e        o_sel
);

  // Priority encoder; a killed (stalled/invalid) operand never forwards.
  always_comb begin
    o_sel = FWD_NONE;
    if (!i_kill && i_use) begin
      if (i_ex_we && (i_ex_rd == i_src))        o_sel = FWD_EXEC;
      else if (i_mem_we && (i_mem_rd == i_src)) o_sel = FWD_MEM;
      else if (i_wb_we && (i_wb_rd == i_src))   o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the ID/EXEC/MEM/WB pipeline: forward selects for the
// instruction in ID, a per-register countdown scoreboard for long-latency
// producers, plus a saturating stall counter and sticky stall timeout.
//
// Flow control: ID offers an instruction with id_valid. The unit accepts it
// (issue=1) in the same cycle when it is not stalled and not flushed. While
// stall=1 the instruction must be held unchanged in ID; flush drops it
// without accepting it. No state is updated by an instruction that does not
// issue.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int RA_W      = 3,
  parameter int LOAD_LAT  = 1,   // 1..15, must fit in CNT_W
  parameter int CNT_W     = 4,
  parameter int PERF_W    = 16,
  parameter int MAX_STALL = 32,
  localparam int NUM_REGS = 2 ** RA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [RA_W-1:0]     id_ra,
  input  logic [RA_W-1:0]     id_rb,
  input  logic                id_use_a,
  input  logic                id_use_b,
  input  logic [RA_W-1:0]     id_rd,
  input  logic                id_we,
  input  logic                id_long,
  input  logic                flush,
  input  logic [RA_W-1:0]     ex_rd,
  input  logic [RA_W-1:0]     mem_rd,
  input  logic [RA_W-1:0]     wb_rd,
  input  logic                ex_we,
  input  logic                mem_we,
  input  logic                wb_we,
  output logic                stall,
  output logic                issue,
  output logic [FWD_W-1:0]    forw_a_ctrl,
  output logic [FWD_W-1:0]    forw_b_ctrl,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [PERF_W-1:0]   stall_cycles,
  output logic                stall_timeout
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [CNT_W-1:0]  r_cnt [NUM_REGS];
  logic [PERF_W-1:0] r_stall_cycles;
  logic [RUN_W-1:0]  r_run;
  logic              r_timeout;

  logic     w_pend_a;
  logic     w_pend_b;
  logic     w_stall;
  logic     w_issue;
  logic     w_kill;
  logic     w_set_long;
  fwd_sel_e w_fwd_a;
  fwd_sel_e w_fwd_b;

  // Stall/issue are purely combinational on the scoreboard so reset drops them at once.
  always_comb begin
    w_pend_a   = id_use_a && (r_cnt[id_ra] != '0);
    w_pend_b   = id_use_b && (r_cnt[id_rb] != '0);
    w_stall    = id_valid && (w_pend_a || w_pend_b);
    w_issue    = id_valid && !w_stall && !flush;
    w_kill     = w_stall || !id_valid;
    w_set_long = w_issue && id_we && id_long;
  end

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .i_src    (id_ra),
    .i_use    (id_use_a),
    .i_kill   (w_kill),
    .i_ex_rd  (ex_rd),
    .i_ex_we  (ex_we),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_we),
    .i_wb_rd  (wb_rd),
    .i_wb_we  (wb_we),
    .o_sel    (w_fwd_a)
  );

  hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .i_src    (id_rb),
    .i_use    (id_use_b),
    .i_kill   (w_kill),
    .i_ex_rd  (ex_rd),
    .i_ex_we  (ex_we),
    .i_mem_rd (mem_rd),
    .i_mem_we (mem_we),
    .i_wb_rd  (wb_rd),
    .i_wb_we  (wb_we),
    .o_sel    (w_fwd_b)
  );

  // Scoreboard countdown: a newly issued long op reloads its register, winning over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_set_long && (id_rd == RA_W'(r))) r_cnt[r] <= CNT_W'(LOAD_LAT);
        else if (r_cnt[r] != '0)              r_cnt[r] <= r_cnt[r] - CNT_W'(1);
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + PERF_W'(1);
  end

  // Consecutive-stall run length; the flag latches when the run reaches MAX_STALL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else if (w_stall) begin
      if (r_run != RUN_MAX)              r_run <= r_run + RUN_W'(1);
      if (r_run >= RUN_MAX - RUN_W'(1))  r_timeout <= 1'b1;
    end else begin
      r_run <= '0;
    end
  end

  // Output mapping.
  always_comb begin
    stall         = w_stall;
    issue         = w_issue;
    forw_a_ctrl   = w_fwd_a;
    forw_b_ctrl   = w_fwd_b;
    stall_cycles  = r_stall_cycles;
    stall_timeout = r_timeout;
    for (int r = 0; r < NUM_REGS; r++) busy_mask[r] = (r_cnt[r] != '0);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Three instances share one stimulus
// bus: A (LOAD_LAT=1), B (LOAD_LAT=3), C (LOAD_LAT=15, MAX_STALL=8, PERF_W=4)
// so that long stall runs and counter saturation stay short.
module tb_hazard_scoreboard;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_use_a, id_use_b, id_we, id_long, flush;
  logic [2:0] id_ra, id_rb, id_rd, ex_rd, mem_rd, wb_rd;
  logic       ex_we, mem_we, wb_we;

  logic       a_stall, a_issue, a_to;
  logic [2:0] a_fwa, a_fwb;
  logic [7:0] a_busy;
  logic [15:0] a_scyc;
  logic       b_stall, b_issue, b_to;
  logic [2:0] b_fwa, b_fwb;
  logic [7:0] b_busy;
  logic [15:0] b_scyc;
  logic       c_stall, c_issue, c_to;
  logic [2:0] c_fwa, c_fwb;
  logic [7:0] c_busy;
  logic [3:0] c_scyc;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  hazard_scoreboard #(.LOAD_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_we(id_we),
    .id_long(id_long), .flush(flush), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .stall(a_stall), .issue(a_issue),
    .forw_a_ctrl(a_fwa), .forw_b_ctrl(a_fwb), .busy_mask(a_busy),
    .stall_cycles(a_scyc), .stall_timeout(a_to));

  hazard_scoreboard #(.LOAD_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_we(id_we),
    .id_long(id_long), .flush(flush), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .stall(b_stall), .issue(b_issue),
    .forw_a_ctrl(b_fwa), .forw_b_ctrl(b_fwb), .busy_mask(b_busy),
    .stall_cycles(b_scyc), .stall_timeout(b_to));

  hazard_scoreboard #(.LOAD_LAT(15), .MAX_STALL(8), .PERF_W(4)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rd(id_rd), .id_we(id_we),
    .id_long(id_long), .flush(flush), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .stall(c_stall), .issue(c_issue),
    .forw_a_ctrl(c_fwa), .forw_b_ctrl(c_fwb), .busy_mask(c_busy),
    .stall_cycles(c_scyc), .stall_timeout(c_to));

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic v, input logic [2:0] ra, input logic [2:0] rb,
                        input logic ua, input logic ub, input logic [2:0] rd,
                        input logic we, input logic lg, input logic fl);
    id_valid = v; id_ra = ra; id_rb = rb; id_use_a = ua; id_use_b = ub;
    id_rd = rd; id_we = we; id_long = lg; flush = fl;
    #1;
  endtask

  task automatic set_stages(input logic [2:0] er, input logic ew, input logic [2:0] mr,
                            input logic mw, input logic [2:0] wr, input logic ww);
    ex_rd = er; ex_we = ew; mem_rd = mr; mem_we = mw; wb_rd = wr; wb_we = ww;
    #1;
  endtask

  // Advance to just after the next rising edge; inputs change there, checks follow.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_stages(0, 0, 0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_id(1, 1, 2, 1, 1, 3, 1, 1, 0);
    set_stages(0, 0, 0, 0, 0, 0);
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    n_cmp++; if (a_busy !== 8'h00) begin n_err++; $display("FAIL reset_busy: got %h want 00", a_busy); end
    n_cmp++; if (a_scyc !== 16'h0) begin n_err++; $display("FAIL reset_scyc: got %h want 0", a_scyc); end
    n_cmp++; if (c_to !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", c_to); end
    n_cmp++; if (a_issue !== 1'b1) begin n_err++; $display("FAIL reset_issue: got %b want 1", a_issue); end
    set_id(1, 1, 2, 1, 1, 3, 1, 1, 1);
    n_cmp++; if (a_issue !== 1'b0) begin n_err++; $display("FAIL reset_issue_flush: got %b want 0", a_issue); end
    rst = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1, 1, 2, 1, 1, 4, 1, 0, 0);
    set_stages(1, 1, 0, 0, 2, 1);
    n_cmp++; if (a_fwa !== 3'd1) begin n_err++; $display("FAIL fwd_add_a: got %0d want 1", a_fwa); end
    n_cmp++; if (a_fwb !== 3'd3) begin n_err++; $display("FAIL fwd_add_b: got %0d want 3", a_fwb); end
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL fwd_add_stall: got %b want 0", a_stall); end
    n_cmp++; if (a_issue !== 1'b1) begin n_err++; $display("FAIL fwd_add_issue: got %b want 1", a_issue); end
    set_id(1, 5, 5, 1, 1, 4, 1, 0, 0);
    set_stages(5, 1, 5, 1, 5, 1);
    n_cmp++; if (a_fwa !== 3'd1) begin n_err++; $display("FAIL fwd_prio_exec: got %0d want 1", a_fwa); end
    set_stages(5, 0, 5, 1, 5, 1);
    n_cmp++; if (a_fwa !== 3'd2) begin n_err++; $display("FAIL fwd_prio_mem_a: got %0d want 2", a_fwa); end
    n_cmp++; if (a_fwb !== 3'd2) begin n_err++; $display("FAIL fwd_prio_mem_b: got %0d want 2", a_fwb); end
    set_stages(5, 0, 5, 0, 5, 1);
    n_cmp++; if (a_fwa !== 3'd3) begin n_err++; $display("FAIL fwd_prio_wb: got %0d want 3", a_fwa); end
    set_stages(5, 0, 5, 0, 5, 0);
    n_cmp++; if (a_fwa !== 3'd0) begin n_err++; $display("FAIL fwd_none: got %0d want 0", a_fwa); end
    set_stages(5, 1, 5, 1, 5, 1);
    set_id(1, 5, 5, 1, 0, 4, 1, 0, 0);
    n_cmp++; if (a_fwb !== 3'd0) begin n_err++; $display("FAIL fwd_unused_b: got %0d want 0", a_fwb); end
    set_id(0, 5, 5, 1, 1, 4, 1, 0, 0);
    n_cmp++; if (a_fwa !== 3'd0) begin n_err++; $display("FAIL fwd_invalid: got %0d want 0", a_fwa); end
    n_cmp++; if (a_issue !== 1'b0) begin n_err++; $display("FAIL invalid_issue: got %b want 0", a_issue); end
  endtask

  task automatic test_load_lat1();
    do_reset();
    set_id(1, 0, 0, 1, 0, 3, 1, 1, 0);
    n_cmp++; if (a_issue !== 1'b1) begin n_err++; $display("FAIL l1_load_issue: got %b want 1", a_issue); end
    next_cycle();
    set_id(1, 3, 0, 1, 0, 4, 1, 0, 0);
    set_stages(3, 1, 0, 0, 0, 0);
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL l1_stall: got %b want 1", a_stall); end
    n_cmp++; if (a_issue !== 1'b0) begin n_err++; $display("FAIL l1_stall_issue: got %b want 0", a_issue); end
    n_cmp++; if (a_fwa !== 3'd0) begin n_err++; $display("FAIL l1_stall_fwd: got %0d want 0", a_fwa); end
    n_cmp++; if (a_busy !== 8'h08) begin n_err++; $display("FAIL l1_busy: got %h want 08", a_busy); end
    next_cycle();
    set_stages(0, 0, 3, 1, 0, 0);
    n_cmp++; if (a_stall !== 1'b0) begin n_err++; $display("FAIL l1_release: got %b want 0", a_stall); end
    n_cmp++; if (a_fwa !== 3'd2) begin n_err++; $display("FAIL l1_fwd_mem: got %0d want 2", a_fwa); end
    n_cmp++; if (a_issue !== 1'b1) begin n_err++; $display("FAIL l1_issue: got %b want 1", a_issue); end
    n_cmp++; if (a_scyc !== 16'd1) begin n_err++; $display("FAIL l1_scyc: got %0d want 1", a_scyc); end
  endtask

  task automatic test_load_lat3();
    logic [7:0] exp_busy;
    do_reset();
    set_id(1, 0, 0, 1, 0, 5, 1, 1, 0);
    next_cycle();
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
    exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h20); exp_q.push_back(8'h00);
    for (int k = 0; k < 4; k++) begin
      exp_busy = exp_q.pop_front();
      n_cmp++; if (b_busy !== exp_busy) begin n_err++; $display("FAIL l3_busy[%0d]: got %h want %h", k, b_busy, exp_busy); end
      n_cmp++; if (b_stall !== (k < 3)) begin n_err++; $display("FAIL l3_stall[%0d]: got %b want %b", k, b_stall, (k < 3)); end
      if (k < 3) next_cycle();
    end
    n_cmp++; if (b_issue !== 1'b1) begin n_err++; $display("FAIL l3_issue: got %b want 1", b_issue); end
    n_cmp++; if (b_scyc !== 16'd3) begin n_err++; $display("FAIL l3_scyc: got %0d want 3", b_scyc); end
  endtask

  task automatic test_reload();
    do_reset();
    set_id(1, 0, 0, 1, 0, 4, 1, 1, 0);
    next_cycle();
    set_id(1, 0, 0, 1, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      if (k == 3) set_id(1, 0, 0, 1, 0, 4, 1, 1, 0);
      if (k == 4) set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n_cmp++; if (b_busy[4] !== 1'b1) begin n_err++; $display("FAIL reload_busy4[%0d]: got %b want 1", k, b_busy[4]); end
      if (k == 3) begin
        n_cmp++; if (b_issue !== 1'b1) begin n_err++; $display("FAIL reload_issue: got %b want 1", b_issue); end
      end
      next_cycle();
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 0, 0, 1, 0, 6, 1, 1, 1);
    n_cmp++; if (b_issue !== 1'b0) begin n_err++; $display("FAIL flush_issue: got %b want 0", b_issue); end
    next_cycle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (b_busy !== 8'h00) begin n_err++; $display("FAIL flush_no_set: got %h want 00", b_busy); end
    set_id(1, 0, 0, 1, 0, 2, 1, 1, 0);
    next_cycle();
    set_id(1, 2, 0, 1, 0, 3, 1, 0, 1);
    n_cmp++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL flush_stall: got %b want 1", b_stall); end
    n_cmp++; if (b_issue !== 1'b0) begin n_err++; $display("FAIL flush_stall_issue: got %b want 0", b_issue); end
    next_cycle();
    n_cmp++; if (b_busy !== 8'h04) begin n_err++; $display("FAIL flush_cnt_runs: got %h want 04", b_busy); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 0, 0, 1, 0, 7, 1, 1, 0);
    next_cycle();
    set_id(1, 7, 0, 1, 0, 1, 1, 0, 0);
    next_cycle();
    n_cmp++; if (b_stall !== 1'b1) begin n_err++; $display("FAIL mid_pre_stall: got %b want 1", b_stall); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (b_stall !== 1'b0) begin n_err++; $display("FAIL mid_stall: got %b want 0", b_stall); end
    n_cmp++; if (b_busy !== 8'h00) begin n_err++; $display("FAIL mid_busy: got %h want 00", b_busy); end
    n_cmp++; if (b_scyc !== 16'd0) begin n_err++; $display("FAIL mid_scyc: got %0d want 0", b_scyc); end
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_timeout_saturate();
    do_reset();
    set_id(1, 0, 0, 1, 0, 1, 1, 1, 0);
    next_cycle();
    // dependent long op on r1: stalls 15 cycles in C, then reloads r1 on issue
    set_id(1, 1, 0, 1, 0, 1, 1, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      if (k == 8) begin
        n_cmp++; if (c_to !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", c_to); end
      end
      if (k == 9) begin
        n_cmp++; if (c_to !== 1'b1) begin n_err++; $display("FAIL to_set: got %b want 1", c_to); end
      end
      next_cycle();
    end
    n_cmp++; if (c_stall !== 1'b0) begin n_err++; $display("FAIL to_release: got %b want 0", c_stall); end
    n_cmp++; if (c_scyc !== 4'd15) begin n_err++; $display("FAIL scyc_15: got %0d want 15", c_scyc); end
    next_cycle();
    set_id(1, 1, 0, 1, 0, 2, 1, 0, 0);
    for (int k = 0; k < 16; k++) next_cycle();
    n_cmp++; if (c_stall !== 1'b0) begin n_err++; $display("FAIL sat_release: got %b want 0", c_stall); end
    n_cmp++; if (c_scyc !== 4'hF) begin n_err++; $display("FAIL scyc_sat: got %0d want 15", c_scyc); end
    n_cmp++; if (c_to !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", c_to); end
    n_cmp++; if (b_to !== 1'b0) begin n_err++; $display("FAIL to_b_short_runs: got %b want 0", b_to); end
  endtask

  task automatic test_same_reg();
    do_reset();
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0);
    set_stages(3, 1, 0, 0, 0, 0);
    n_cmp++; if ({a_fwa, a_fwb} !== {3'd1, 3'd1}) begin n_err++; $display("FAIL same_fwd: got %0d/%0d want 1/1", a_fwa, a_fwb); end
    set_id(1, 0, 0, 1, 0, 3, 1, 1, 0);
    set_stages(0, 0, 0, 0, 0, 0);
    next_cycle();
    set_id(1, 3, 3, 1, 1, 4, 1, 0, 0);
    set_stages(3, 1, 0, 0, 0, 0);
    n_cmp++; if (a_stall !== 1'b1) begin n_err++; $display("FAIL same_stall: got %b want 1", a_stall); end
    n_cmp++; if ({a_fwa, a_fwb} !== 6'd0) begin n_err++; $display("FAIL same_stall_fwd: got %0d/%0d want 0/0", a_fwa, a_fwb); end
    next_cycle();
    set_stages(0, 0, 3, 1, 0, 0);
    n_cmp++; if ({a_fwa, a_fwb} !== {3'd2, 3'd2}) begin n_err++; $display("FAIL same_mem: got %0d/%0d want 2/2", a_fwa, a_fwb); end
    n_cmp++; if (a_scyc !== 16'd1) begin n_err++; $display("FAIL same_scyc: got %0d want 1", a_scyc); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_stages(0, 0, 0, 0, 0, 0);
    test_reset();
    test_forward();
    test_load_lat1();
    test_load_lat3();
    test_reload();
    test_flush();
    test_reset_mid_stall();
    test_timeout_saturate();
    test_same_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
